// File: rtl/weight_loader_if.sv
// weight_loader_if: upstream word stream, column-buffer write bus and load status
interface weight_loader_if #(
  parameter int SYS_COLS   = 4,
  parameter int W_BITWIDTH = 8
);
  logic                  start;
  logic                  i_valid;
  logic [W_BITWIDTH-1:0] i_data;
  logic                  i_ready;
  logic [SYS_COLS-1:0]   full;
  logic [SYS_COLS-1:0]   o_wr_en;
  logic [W_BITWIDTH-1:0] o_wr_data;
  logic                  busy;
  logic                  done;
  modport master (
    output start, i_valid, i_data, full,
    input  i_ready, o_wr_en, o_wr_data, busy, done
  );
  modport slave (
    input  start, i_valid, i_data, full,
    output i_ready, o_wr_en, o_wr_data, busy, done
  );
endinterface

// File: rtl/weight_loader.sv
// weight_loader: streams SYS_COLS*W_ROWS weight words column-major into per-column buffers
module weight_loader #(
  parameter int SYS_COLS   = 4,
  parameter int W_BITWIDTH = 8,
  parameter int W_ROWS     = 3
) (
  input logic           clk,
  input logic           rst,
  weight_loader_if.slave bus
);
  localparam int CW = SYS_COLS > 1 ? $clog2(SYS_COLS) : 1;
  localparam int RW = W_ROWS > 1 ? $clog2(W_ROWS) : 1;
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t        state;
  logic [RW-1:0] row_cnt;
  logic [CW-1:0] col_cnt;
  logic          acc;
  logic          last_row;
  logic          last_col;
  assign bus.i_ready   = (state == LOAD) && !bus.full[col_cnt];
  assign acc           = bus.i_valid && bus.i_ready;
  assign bus.o_wr_en   = acc ? SYS_COLS'(1) << col_cnt : '0;
  assign bus.o_wr_data = acc ? bus.i_data : '0;
  assign bus.busy      = state == LOAD;
  assign bus.done      = state == DONE;
  assign last_row      = row_cnt == RW'(W_ROWS - 1);
  assign last_col      = col_cnt == CW'(SYS_COLS - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      row_cnt <= '0;
      col_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          state   <= LOAD;
          row_cnt <= '0;
          col_cnt <= '0;
        end
        LOAD: if (acc) begin
          row_cnt <= last_row ? '0 : row_cnt + 1'b1;
          if (last_row) begin
            col_cnt <= last_col ? '0 : col_cnt + 1'b1;
            state   <= last_col ? DONE : LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_weight_loader.sv
// tb_weight_loader: table-driven directed checks of weight_loader with 4 columns x 3 rows of 8-bit words
module tb_weight_loader;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  weight_loader_if #(.SYS_COLS(4), .W_BITWIDTH(8)) bus ();
  weight_loader #(.SYS_COLS(4), .W_BITWIDTH(8), .W_ROWS(3)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic       st;
    logic       v;
    logic [7:0] d;
    logic [3:0] f;
    logic       rdy;
    logic [3:0] we;
    logic [7:0] wd;
    logic       bsy;
    logic       dn;
  } vec_t;
  vec_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  task automatic chk(input string nm, input int i, input logic [7:0] a, input logic [7:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s[%0d] got %h want %h", nm, i, a, e);
    end
  endtask
  function automatic void add(input logic st, v, input logic [7:0] d, input logic [3:0] f,
                              input logic rdy, input logic [3:0] we, input logic [7:0] wd,
                              input logic bsy, dn);
    vec_t x;
    x.st = st; x.v = v; x.d = d; x.f = f; x.rdy = rdy; x.we = we; x.wd = wd; x.bsy = bsy; x.dn = dn;
    q.push_back(x);
  endfunction
  function automatic logic [3:0] col_oh(input int k);
    logic [3:0] one = 4'b0001;
    return one << (k / 3);
  endfunction
  function automatic void add_full_load();
    add(1, 0, 8'h00, 4'b0000, 0, 4'b0000, 8'h00, 0, 0);
    for (int k = 0; k < 12; k++)
      add(0, 1, 8'(k + 1), 4'b0000, 1, col_oh(k), 8'(k + 1), 1, 0);
    add(0, 0, 8'h00, 4'b0000, 0, 4'b0000, 8'h00, 0, 1);
    add(0, 0, 8'h00, 4'b0000, 0, 4'b0000, 8'h00, 0, 0);
  endfunction
  task automatic drive(input logic st, v, input logic [7:0] d, input logic [3:0] f);
    bus.start = st; bus.i_valid = v; bus.i_data = d; bus.full = f;
  endtask
  task automatic check_outs(input string nm, input int i, input logic rdy, input logic [3:0] we,
                            input logic [7:0] wd, input logic bsy, dn);
    chk({nm, ".i_ready"}, i, 8'(bus.i_ready), 8'(rdy));
    chk({nm, ".o_wr_en"}, i, 8'(bus.o_wr_en), 8'(we));
    chk({nm, ".o_wr_data"}, i, bus.o_wr_data, wd);
    chk({nm, ".busy"}, i, 8'(bus.busy), 8'(bsy));
    chk({nm, ".done"}, i, 8'(bus.done), 8'(dn));
  endtask
  task automatic run_q(input string nm);
    foreach (q[i]) begin
      @(posedge clk); #1;
      drive(q[i].st, q[i].v, q[i].d, q[i].f);
      @(negedge clk);
      check_outs(nm, i, q[i].rdy, q[i].we, q[i].wd, q[i].bsy, q[i].dn);
    end
    q.delete();
  endtask
  task automatic async_reset(input string nm);
    #2 rst = 1;
    #1 check_outs(nm, 0, 0, 4'b0000, 8'h00, 0, 0);
    @(posedge clk); #1;
    drive(0, 0, 8'h00, 4'b0000);
    rst = 0;
  endtask
  initial begin
    int n;
    drive(0, 0, 8'h00, 4'b0000);
    #2 check_outs("reset", 0, 0, 4'b0000, 8'h00, 0, 0);
    @(posedge clk); #1 rst = 0;
    add_full_load();
    run_q("full_load");
    add(1, 0, 8'h00, 4'b0000, 0, 4'b0000, 8'h00, 0, 0);
    for (int k = 0; k < 3; k++)
      add(0, 1, 8'(k + 1), 4'b0100, 1, 4'b0001, 8'(k + 1), 1, 0);
    add(0, 1, 8'h04, 4'b0000, 1, 4'b0010, 8'h04, 1, 0);
    for (int k = 0; k < 3; k++)
      add(0, 1, 8'h05, 4'b0010, 0, 4'b0000, 8'h00, 1, 0);
    for (int k = 4; k < 12; k++)
      add(0, 1, 8'(k + 1), 4'b0000, 1, col_oh(k), 8'(k + 1), 1, 0);
    add(0, 0, 8'h00, 4'b0000, 0, 4'b0000, 8'h00, 0, 1);
    run_q("backpressure");
    add(1, 0, 8'h00, 4'b0000, 0, 4'b0000, 8'h00, 0, 0);
    n = 0;
    for (int k = 0; k < 200 && n < 12; k++) begin
      logic v;
      v = (k == 3) ? 1'b0 : 1'($urandom_range(0, 1));
      if (v) begin
        add(0, 1, 8'(n + 1), 4'b0000, 1, col_oh(n), 8'(n + 1), 1, 0);
        n++;
      end else
        add(k == 3, 0, 8'hEE, 4'b0000, 1, 4'b0000, 8'h00, 1, 0);
    end
    add(0, 0, 8'h00, 4'b0000, 0, 4'b0000, 8'h00, 0, 1);
    add(0, 0, 8'h00, 4'b0000, 0, 4'b0000, 8'h00, 0, 0);
    run_q("gaps");
    add(0, 1, 8'hAA, 4'b0000, 0, 4'b0000, 8'h00, 0, 0);
    add(1, 1, 8'hAA, 4'b0000, 0, 4'b0000, 8'h00, 0, 0);
    add(0, 1, 8'hAA, 4'b0000, 1, 4'b0001, 8'hAA, 1, 0);
    for (int k = 1; k < 12; k++)
      add(0, 1, 8'(k + 1), 4'b0000, 1, col_oh(k), 8'(k + 1), 1, 0);
    add(0, 0, 8'h00, 4'b0000, 0, 4'b0000, 8'h00, 0, 1);
    run_q("idle_words");
    add(1, 0, 8'h00, 4'b0000, 0, 4'b0000, 8'h00, 0, 0);
    add(0, 1, 8'h31, 4'b0000, 1, 4'b0001, 8'h31, 1, 0);
    add(0, 1, 8'h32, 4'b0000, 1, 4'b0001, 8'h32, 1, 0);
    add(0, 1, 8'h33, 4'b0000, 1, 4'b0001, 8'h33, 1, 0);
    run_q("pre_async");
    async_reset("async_rst");
    add(1, 0, 8'h00, 4'b0000, 0, 4'b0000, 8'h00, 0, 0);
    for (int k = 0; k < 5; k++)
      add(0, 1, 8'(k + 1), 4'b0000, 1, col_oh(k), 8'(k + 1), 1, 0);
    run_q("pre_midload");
    async_reset("midload_rst");
    for (int k = 0; k < 3; k++)
      add(0, 1, 8'h77, 4'b0000, 0, 4'b0000, 8'h00, 0, 0);
    run_q("post_rst_idle");
    add_full_load();
    run_q("reload");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/weight_loader.md
WEIGHT_LOADER -- requirements
Module: weight_loader

Interface
REQ-001 Parameter SYS_COLS, default Config::sys_cols, number of weight column buffers to fill.
REQ-002 Parameter W_BITWIDTH, default Config::W_BITWIDTH, width of one weight word.
REQ-003 Parameter W_ROWS, default Config::W_rows, number of words written to each column buffer per load.
REQ-004 The module SHALL have one clock and an asynchronous, active-high reset; all port directions and widths are listed in REQ-005..REQ-015.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  single-cycle request to begin a load.
REQ-008 i_valid  input  1  upstream word valid.
REQ-009 i_data  input  W_BITWIDTH  upstream weight word.
REQ-010 i_ready  output  1  loader accepts i_data this cycle.
REQ-011 full  input  SYS_COLS  per-column buffer full flags; bit c from column buffer c.
REQ-012 o_wr_en  output  SYS_COLS  per-column write enables; one-hot or zero; bit c to wr_en of column buffer c.
REQ-013 o_wr_data  output  W_BITWIDTH  write data, shared by all column buffers' din.
REQ-014 busy  output  1  high while in LOAD.
REQ-015 done  output  1  single-cycle pulse when a load completes.

Function
REQ-016 States SHALL be IDLE, LOAD and DONE; the state register, row_cnt (0..W_ROWS-1) and col_cnt (0..SYS_COLS-1) are the only sequential state.
REQ-017 IDLE -> LOAD on start=1, clearing row_cnt and col_cnt to 0; start SHALL be ignored in LOAD and DONE.
REQ-018 i_ready SHALL be (state==LOAD) and not full[col_cnt]; it SHALL NOT depend on i_valid.
REQ-019 A word is accepted in a cycle where i_valid=1 and i_ready=1; no other cycle accepts a word.
REQ-020 On acceptance, o_wr_en SHALL equal 1<<col_cnt and o_wr_data SHALL equal i_data in the same cycle, combinationally, with zero latency; otherwise o_wr_en SHALL be 0.
REQ-021 o_wr_data SHALL be 0 whenever o_wr_en is 0.
REQ-022 Counter update on acceptance:
  - row_cnt increments.
  - At row_cnt=W_ROWS-1, row_cnt wraps to 0 and col_cnt increments.
REQ-023 Acceptance at row_cnt=W_ROWS-1 and col_cnt=SYS_COLS-1 SHALL move LOAD -> DONE and return both counters to 0.
REQ-024 In DONE, done SHALL be 1 for exactly that one cycle, and the next state SHALL be IDLE; done SHALL be 0 in all other states.
REQ-025 busy SHALL be 1 exactly when state==LOAD.
REQ-026 Cycles with i_valid=0, or with full[col_cnt]=1, SHALL hold all counters unchanged and write nothing.
REQ-027 full bits of columns other than col_cnt SHALL have no effect.
REQ-028 Words presented while not in LOAD SHALL NOT be accepted and SHALL NOT be written.
REQ-029 Each load SHALL write exactly SYS_COLS*W_ROWS words in column-major order:
  - Column 0 receives words 0..W_ROWS-1, column 1 the next W_ROWS words, and so on.
  - Every column receives exactly W_ROWS words.

Reset
REQ-030 While rst=1, the following SHALL be forced immediately, independent of clk:
  - State = IDLE, row_cnt = 0, col_cnt = 0.
  - i_ready = 0, o_wr_en = 0, o_wr_data = 0, busy = 0, done = 0.
REQ-031 Reset asserted mid-load SHALL abandon the load, with no further writes and no done pulse; the next start SHALL begin again at column 0, row 0.
REQ-032 The first start is honoured on the first rising edge after rst deasserts.

Verification (SYS_COLS=4, W_ROWS=3, W_BITWIDTH=8)
REQ-033 Reset: assert rst asynchronously mid-cycle -> all outputs read 0 before the next edge; state reads IDLE.
REQ-034 Full load: pulse start, then present words 0x01..0x0C back-to-back with full=0 ->
  - Column 0 is written 01,02,03 and column 3 is written 0A,0B,0C.
  - o_wr_en is one-hot on exactly 12 cycles.
  - done pulses the cycle after word 0x0C; busy falls that same cycle.
REQ-035 Backpressure: hold full[1]=1 while col_cnt=1 and row_cnt=1 for 3 cycles ->
  - i_ready=0 and o_wr_en=0 for those 3 cycles.
  - Word 0x05 is held, then written to column 1 when full[1] drops.
  - full[2]=1 during column 0 writes has no effect.
REQ-036 Gaps and ignored start: toggle i_valid randomly, and pulse start during LOAD ->
  - The same 12-word column-major result as REQ-034.
  - The extra start has no effect.
REQ-037 Idle words: present i_valid=1 with data 0xAA before start -> i_ready=0 and no write; after start, 0xAA is written as the first word, to column 0.
REQ-038 Reset mid-load: assert rst after 5 accepted words -> no done pulse; a new start plus 12 words reproduces REQ-034 exactly.
